// File: rtl/ascon_perm_sched_pkg.sv
// Shared constants, FSM encoding and round-constant helper for the Ascon
// permutation round scheduler.
package ascon_perm_sched_pkg;
  localparam int X_SIZE     = 64;
  localparam int STATE_W    = 320;
  localparam int ROUNDS_A   = 12;
  localparam int ROUNDS_B   = 6;
  localparam int ROUNDS_MAX = 12;
  localparam int N_REQ      = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fsm_e;

  // c_r = {4'hF - idx, idx}; no wrap for idx 0..11
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return 8'hF0 - {idx, 4'h0} + {4'h0, idx};
  endfunction
endpackage

// File: rtl/ascon_perm_sched_if.sv
// Request/response bundle between the mode controller and the round scheduler.
interface ascon_perm_sched_if;
  import ascon_perm_sched_pkg::*;

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [STATE_W-1:0] req_state0;
  logic [STATE_W-1:0] req_state1;
  logic [3:0]         req_rounds0;
  logic [3:0]         req_rounds1;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [STATE_W-1:0] rsp_state;
  logic               rsp_id;
  logic               busy;

  modport master (
    output req_valid, req_state0, req_state1, req_rounds0, req_rounds1, rsp_ready,
    input  req_ready, rsp_valid, rsp_state, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_state0, req_state1, req_rounds0, req_rounds1, rsp_ready,
    output req_ready, rsp_valid, rsp_state, rsp_id, busy
  );
endinterface

// File: rtl/ascon_perm_sched_p.sv
// Single Ascon round: constant addition into x2, 5-bit S-box layer, linear layer.
module ascon_p
  import ascon_perm_sched_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic [7:0]         i_cr,
  output logic [STATE_W-1:0] o_state
);
  function automatic logic [X_SIZE-1:0] rotr(input logic [X_SIZE-1:0] x, input int k);
    return (x >> k) | (x << (X_SIZE - k));
  endfunction

  logic [X_SIZE-1:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [X_SIZE-1:0] w_a0, w_a2, w_a4;
  logic [X_SIZE-1:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [X_SIZE-1:0] w_c0, w_c1, w_c2, w_c3, w_c4;

  assign w_x0 = i_state[0*X_SIZE +: X_SIZE];
  assign w_x1 = i_state[1*X_SIZE +: X_SIZE];
  assign w_x2 = i_state[2*X_SIZE +: X_SIZE] ^ {{(X_SIZE-8){1'b0}}, i_cr};
  assign w_x3 = i_state[3*X_SIZE +: X_SIZE];
  assign w_x4 = i_state[4*X_SIZE +: X_SIZE];

  // bitsliced S-box: pre-mix, chi, post-mix
  assign w_a0 = w_x0 ^ w_x4;
  assign w_a2 = w_x2 ^ w_x1;
  assign w_a4 = w_x4 ^ w_x3;

  assign w_b0 = w_a0 ^ (~w_x1 & w_a2);
  assign w_b1 = w_x1 ^ (~w_a2 & w_x3);
  assign w_b2 = w_a2 ^ (~w_x3 & w_a4);
  assign w_b3 = w_x3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_x1);

  assign w_c0 = w_b0 ^ w_b4;
  assign w_c1 = w_b1 ^ w_b0;
  assign w_c2 = ~w_b2;
  assign w_c3 = w_b3 ^ w_b2;
  assign w_c4 = w_b4;

  assign o_state[0*X_SIZE +: X_SIZE] = w_c0 ^ rotr(w_c0, 19) ^ rotr(w_c0, 28);
  assign o_state[1*X_SIZE +: X_SIZE] = w_c1 ^ rotr(w_c1, 61) ^ rotr(w_c1, 39);
  assign o_state[2*X_SIZE +: X_SIZE] = w_c2 ^ rotr(w_c2,  1) ^ rotr(w_c2,  6);
  assign o_state[3*X_SIZE +: X_SIZE] = w_c3 ^ rotr(w_c3, 10) ^ rotr(w_c3, 17);
  assign o_state[4*X_SIZE +: X_SIZE] = w_c4 ^ rotr(w_c4,  7) ^ rotr(w_c4, 41);
endmodule

// File: rtl/ascon_perm_sched.sv
// Round scheduler/arbiter: owns the 320-bit working state, grants one of two
// requesters round-robin and runs one ascon_p round per cycle.
module ascon_perm_sched
  import ascon_perm_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ascon_perm_sched_if.slave  bus
);
  fsm_e               r_fsm, w_fsm_nxt;
  logic [STATE_W-1:0] r_state, w_round_out, w_req_state;
  logic [3:0]         r_idx, w_n, w_n_eff;
  logic [7:0]         w_cr;
  logic               r_id, r_last, r_busy, r_rsp_valid;
  logic               w_win, w_accept;

  // tie goes to whoever was not granted last; otherwise the lone valid wins
  assign w_win    = (&bus.req_valid) ? ~r_last : bus.req_valid[1];
  assign w_accept = (r_fsm == S_IDLE) && (|bus.req_valid);

  assign bus.req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  assign w_n         = w_win ? bus.req_rounds1 : bus.req_rounds0;
  assign w_n_eff     = (w_n > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : w_n;
  assign w_req_state = w_win ? bus.req_state1 : bus.req_state0;
  assign w_cr        = round_const(r_idx);

  ascon_p u_round (
    .i_state (r_state),
    .i_cr    (w_cr),
    .o_state (w_round_out)
  );

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: if (w_accept) w_fsm_nxt = (w_n == 4'd0) ? S_HOLD : S_RUN;
      S_RUN:  if (r_idx == 4'd11) w_fsm_nxt = S_HOLD;
      S_HOLD: if (r_rsp_valid && bus.rsp_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_idx       <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_busy <= (w_fsm_nxt != S_IDLE);
      // IDLE->HOLD (n = 0) still costs one cycle before the response shows
      r_rsp_valid <= (w_fsm_nxt == S_HOLD) && (r_fsm != S_IDLE);
      case (r_fsm)
        S_IDLE: if (w_accept) begin
          r_state <= w_req_state;
          r_id    <= w_win;
          r_last  <= w_win;
          r_idx   <= 4'd12 - w_n_eff;
        end
        S_RUN: begin
          r_state <= w_round_out;
          if (r_idx != 4'd11) r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_state = r_state;
  assign bus.rsp_id    = r_id;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed + randomized bench for ascon_perm_sched against a table-driven
// Ascon permutation model.
module tb_ascon_perm_sched;
  logic clk, rst_n;
  ascon_perm_sched_if bus();

  ascon_perm_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [7:0] tr_q[$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rr64(input logic [63:0] x, input int k);
    return (x >> k) | (x << (64 - k));
  endfunction

  // one round: x2 ^= c, column-wise S-box lookup, per-word diffusion
  function automatic logic [319:0] ref_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x[5], y[5];
    logic [4:0]  v, o;
    for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
    x[2][7:0] = x[2][7:0] ^ c;
    for (int b = 0; b < 64; b++) begin
      v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = SBOX[v];
      y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
    end
    return {y[4] ^ rr64(y[4], 7) ^ rr64(y[4], 41),
            y[3] ^ rr64(y[3], 10) ^ rr64(y[3], 17),
            y[2] ^ rr64(y[2], 1) ^ rr64(y[2], 6),
            y[1] ^ rr64(y[1], 61) ^ rr64(y[1], 39),
            y[0] ^ rr64(y[0], 19) ^ rr64(y[0], 28)};
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    int ne = (n > 12) ? 12 : n;
    for (int r = 12 - ne; r < 12; r++) s = ref_round(s, 8'(240 - 15 * r));
    return s;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int k, input logic [319:0] st, input logic [3:0] n);
    if (k == 0) begin bus.req_state0 = st; bus.req_rounds0 = n; end
    else        begin bus.req_state1 = st; bus.req_rounds1 = n; end
    bus.req_valid[k] = 1'b1;
  endtask

  // waits for a grant, checks it went to k, drops k's valid after the accept edge
  task automatic wait_accept(input int k, input string tag, output int waited);
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) break;
      waited++;
    end
    chk({tag, "_ready"}, 320'(bus.req_ready), 320'(2'b01 << k));
    @(posedge clk); #1;
    bus.req_valid[k] = 1'b0;
  endtask

  // called right after the accept edge; leaves the DUT in HOLD
  task automatic wait_rsp(input int k, input logic [319:0] st, input int n, input string tag);
    int ne  = (n > 12) ? 12 : n;
    int cyc = 0;
    tr_q.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      tr_q.push_back(dut.w_cr);
      @(posedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 320'(cyc), 320'((ne == 0) ? 1 : ne));
    for (int j = 0; j < ne && j < tr_q.size(); j++)
      chk({tag, "_cr"}, 320'(tr_q[j]), 320'(240 - 15 * (12 - ne + j)));
    chk({tag, "_state"}, bus.rsp_state, ref_perm(st, n));
    chk({tag, "_id"}, 320'(bus.rsp_id), 320'(k));
    chk({tag, "_busy"}, 320'(bus.busy), 320'(1));
  endtask

  task automatic handshake(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rv_drop"}, 320'(bus.rsp_valid), 320'(0));
    chk({tag, "_busy_drop"}, 320'(bus.busy), 320'(0));
  endtask

  initial begin
    logic [319:0] s0, s1, hold_exp;
    logic [7:0]   exp12 [12];
    int           w, nb;
    bit           saw_rv;

    exp12 = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_state0 = '0; bus.req_state1 = '0;
    bus.req_rounds0 = '0; bus.req_rounds1 = '0; bus.rsp_ready = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 320'(bus.req_ready), 320'(0));
    chk("rst_rv", 320'(bus.rsp_valid), 320'(0));
    chk("rst_state", bus.rsp_state, 320'(0));
    chk("rst_id", 320'(bus.rsp_id), 320'(0));
    chk("rst_busy", 320'(bus.busy), 320'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // requester 0, Ascon-128 init state, 12 rounds
    s0 = {256'h0, 64'h80400c0600000000};
    drive_req(0, s0, 4'd12);
    wait_accept(0, "init", w);
    wait_rsp(0, s0, 12, "init");
    for (int j = 0; j < 12 && j < tr_q.size(); j++) chk("init_crlist", 320'(tr_q[j]), 320'(exp12[j]));
    handshake("init");

    // requester 1, random state, 6 rounds
    s1 = rand320();
    drive_req(1, s1, 4'd6);
    wait_accept(1, "b6", w);
    wait_rsp(1, s1, 6, "b6");
    handshake("b6");

    // both valid continuously: alternating grants, 8-cycle period
    begin
      int gk[$], gc[$], nrsp, acc;
      logic [319:0] eq[$];
      nrsp = 0;
      s0 = rand320(); s1 = rand320();
      drive_req(0, s0, 4'd6); drive_req(1, s1, 4'd6);
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 100 && nrsp < 4; c++) begin
        @(negedge clk);
        acc = -1;
        if (bus.req_ready != 2'b00) begin
          acc = int'(bus.req_ready[1]);
          gk.push_back(acc); gc.push_back(c);
          eq.push_back(ref_perm((acc == 1) ? s1 : s0, 6));
        end
        if (bus.rsp_valid && nrsp < gk.size()) begin
          chk("rr_state", bus.rsp_state, eq[nrsp]);
          chk("rr_id", 320'(bus.rsp_id), 320'(gk[nrsp]));
          // accept edge + 6 rounds, observed on the following negedge
          chk("rr_lat", 320'(c), 320'(gc[nrsp] + 6 + 1));
          nrsp++;
          if (nrsp == 4) bus.req_valid = 2'b00;
        end
        @(posedge clk); #1;
        if (acc == 0) begin s0 = rand320(); bus.req_state0 = s0; end
        if (acc == 1) begin s1 = rand320(); bus.req_state1 = s1; end
      end
      chk("rr_nrsp", 320'(nrsp), 320'(4));
      for (int i = 0; i < 4 && i < gk.size(); i++) chk("rr_order", 320'(gk[i]), 320'(i % 2));
      for (int i = 0; i < 3 && i + 1 < gc.size(); i++) chk("rr_period", 320'(gc[i+1] - gc[i]), 320'(8));
      @(posedge clk); #1;
    end

    // back-pressure in HOLD with requester 1 pending
    bus.rsp_ready = 1'b0;
    s0 = rand320();
    nb = $urandom_range(1, 12);
    drive_req(0, s0, 4'(nb));
    wait_accept(0, "bp", w);
    s1 = rand320();
    drive_req(1, s1, 4'd3);
    wait_rsp(0, s0, nb, "bp");
    hold_exp = ref_perm(s0, nb);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_state", bus.rsp_state, hold_exp);
      chk("bp_hold_id", 320'(bus.rsp_id), 320'(0));
      chk("bp_hold_ready", 320'(bus.req_ready), 320'(0));
      chk("bp_hold_rv", 320'(bus.rsp_valid), 320'(1));
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pre", 320'(bus.req_ready), 320'(0));
    handshake("bp");
    wait_accept(1, "bp_next", w);
    chk("bp_next_wait", 320'(w), 320'(0));
    wait_rsp(1, s1, 3, "bp_next");
    handshake("bp_next");

    // n = 0 passes through; n = 15 clamps to 12
    s0 = rand320();
    drive_req(0, s0, 4'd0);
    wait_accept(0, "n0", w);
    wait_rsp(0, s0, 0, "n0");
    chk("n0_unchanged", bus.rsp_state, s0);
    handshake("n0");
    s1 = rand320();
    drive_req(1, s1, 4'd15);
    wait_accept(1, "n15", w);
    wait_rsp(1, s1, 15, "n15");
    chk("n15_as_12", bus.rsp_state, ref_perm(s1, 12));
    handshake("n15");

    // async reset in round 4
    s1 = rand320();
    drive_req(1, s1, 4'd12);
    wait_accept(1, "ar", w);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_rv", 320'(bus.rsp_valid), 320'(0));
    chk("ar_busy", 320'(bus.busy), 320'(0));
    chk("ar_state", bus.rsp_state, 320'(0));
    chk("ar_id", 320'(bus.rsp_id), 320'(0));
    chk("ar_ready", 320'(bus.req_ready), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw_rv = 1'b0;
    repeat (14) begin
      @(negedge clk);
      saw_rv = saw_rv | bus.rsp_valid | bus.busy;
    end
    chk("ar_no_rsp", 320'(saw_rv), 320'(0));
    @(posedge clk); #1;

    // post-reset tie goes to requester 0, then requester 1
    s0 = rand320(); s1 = rand320();
    drive_req(0, s0, 4'd6); drive_req(1, s1, 4'd12);
    wait_accept(0, "tie0", w);
    wait_rsp(0, s0, 6, "tie0");
    handshake("tie0");
    wait_accept(1, "tie1", w);
    chk("tie1_wait", 320'(w), 320'(0));
    wait_rsp(1, s1, 12, "tie1");
    handshake("tie1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ascon_perm_sched.md
# ascon_perm_sched

Round scheduler and arbiter for the Ascon permutation datapath. It owns the 320-bit working-state register and drives one `ascon_p` round instance, applying one round per cycle with the correct round constant. Two requesters share it: the init/finalization path (a = 12 rounds) and the data-absorb path (b = 6 rounds). It sits between the mode controller and `ascon_p`, so that controller no longer iterates rounds itself.

## Interface
- `ROUNDS_MAX`, 12: maximum rounds per request; a larger request is clamped to this.
- `N_REQ`, 2: number of requesters; fixed at 2 for this revision.

- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_state0`, `req_state1`  in  320 each  input state; x0 in bits [63:0] … x4 in bits [319:256].
- `req_rounds0`, `req_rounds1`  in  4 each  number of rounds n (0..15).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_state`  out  320  permuted state.
- `rsp_id`  out  1  index of the requester that owns `rsp_state`.
- `busy`  out  1  high in RUN and HOLD.

## Operation
- FSM states: IDLE, RUN, HOLD.
- **IDLE.** `req_ready[k]` is combinational and high only for the arbitration winner k.
  - Winner: if exactly one `req_valid` bit is high, that requester wins. If both are high, the requester not granted last time wins (round-robin).
  - On `req_valid[k] & req_ready[k]`:
    - capture `req_state<k>` into the state register and k into `rsp_id`;
    - set n_eff = min(n, ROUNDS_MAX) and `idx` = 12 − n_eff;
    - set `last_grant` = k;
    - go to RUN, or go directly to HOLD if n = 0 (state passes through unchanged).
- **RUN.** Each cycle:
  - state ← `ascon_p`(state, c_r);
  - c_r = {4'hF − idx, idx} in 8 bits, i.e. 8'hF0 − idx·8'h10 + idx;
  - `idx` ← `idx` + 1;
  - when the round with `idx` = 11 completes, go to HOLD.
  - Constant sequence for n = 12: F0 E1 D2 C3 B4 A5 96 87 78 69 5A 4B. For n = 6: 96 87 78 69 5A 4B.
- **HOLD.**
  - `rsp_valid` = 1. `rsp_state` and `rsp_id` are stable until `rsp_valid & rsp_ready`, then go to IDLE.
  - No request is accepted in HOLD or RUN; `req_ready` = 0 in both.
- `idx` is 4 bits and never exceeds 11 in RUN. The c_r arithmetic is 8-bit and has no overflow for idx 0..11.
- Requests that arrive during RUN/HOLD wait. A requester must hold `req_valid` and its inputs stable until accepted.
- Reset (async, any state):
  - abort any operation; no response is issued for it;
  - FSM = IDLE; `last_grant` = 1, so requester 0 wins the first tie.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_state` = 0, `rsp_id` = 0, `busy` = 0, internal state = 0, `idx` = 0.
- Accept at edge T. Rounds execute at edges T+1..T+n. `rsp_valid` is high after edge T+n.
- For n = 0: `rsp_valid` is high after edge T+1.
- The earliest next accept is the cycle after the response handshake. Minimum request-to-request period is n + 2 cycles.
- Response back-pressure: HOLD persists indefinitely while `rsp_ready` = 0.
- Simultaneous `req_valid` = 2'b11 in IDLE resolves in the same cycle; the loser's `req_ready` stays 0.
- `busy` and `rsp_valid` are registered. `req_ready` is combinational from `req_valid`, FSM state and `last_grant`.

## Structure
- Shared package (extension of the existing defines):
  - `X_SIZE` = 64, `STATE_W` = 320, `ROUNDS_A` = 12, `ROUNDS_B` = 6;
  - FSM encodings;
  - a c_r function of idx.
- One sub-module: the existing `ascon_p` single-round core, instantiated once and fed from the state register.
- The arbiter is inline logic: a two-input round-robin with one pointer bit. It is not a separate module.

## Test plan
- Reset, then requester 0 sends n = 12 with the Ascon-128 init state (IV 0x80400c0600000000, key/nonce 0) → `rsp_valid` after exactly 12 rounds; `rsp_state` matches the software model; `rsp_id` = 0; the traced c_r sequence is F0…4B.
- Requester 1 sends n = 6 with a random state → 6 rounds; c_r is 96,87,78,69,5A,4B; `rsp_id` = 1; result matches the model.
- Both requesters are valid continuously with n = 6, `rsp_ready` = 1 → grants alternate 0,1,0,1; each response arrives 6 cycles after its accept; request period is 8 cycles.
- `rsp_ready` is held 0 for 20 cycles in HOLD → `rsp_state` and `rsp_id` are stable; `req_ready` = 0 throughout; a new accept occurs the cycle after `rsp_ready` rises.
- n = 0 returns the state unchanged after 1 cycle. n = 15 is clamped to 12 rounds and matches the n = 12 result.
- `rst` is asserted low in RUN round 4, asynchronously mid-cycle → all outputs reach reset values immediately; no `rsp_valid` follows; the next request runs normally.
